// File: rtl/hello_nios2_qsys_oci_dct_packer_pkg.sv
// DCT packer shared types: atom/frame widths, FSM states, frame bundle.
// No ports; imported by the packer, its interface and the frame register.
package hello_nios2_qsys_oci_dct_packer_pkg;

  localparam int ATOM_W = 2;
  localparam int DEPTH  = 15;
  localparam int CNT_W  = 4;
  localparam int BUF_W  = DEPTH * ATOM_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] buffer;
  } frame_t;

endpackage

// File: rtl/hello_nios2_qsys_oci_dct_packer_if.sv
// Atom-in / frame-out bus of the DCT packer plus live accumulator taps.
// master: atom source + frame writer side; slave: the packer.
interface hello_nios2_qsys_oci_dct_packer_if;
  import hello_nios2_qsys_oci_dct_packer_pkg::*;

  logic              atom_valid;
  logic [ATOM_W-1:0] atom_data;
  logic              atom_ready;
  logic              flush;
  logic              frame_valid;
  logic              frame_ready;
  logic [BUF_W-1:0]  frame_buffer;
  logic [CNT_W-1:0]  frame_count;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              overflow;
  logic              clear_overflow;

  modport master (
    output atom_valid, atom_data, flush,
    output frame_ready, clear_overflow,
    input  atom_ready, frame_valid,
    input  frame_buffer, frame_count,
    input  dct_buffer, dct_count, overflow
  );

  modport slave (
    input  atom_valid, atom_data, flush,
    input  frame_ready, clear_overflow,
    output atom_ready, frame_valid,
    output frame_buffer, frame_count,
    output dct_buffer, dct_count, overflow
  );

endinterface

// File: rtl/hello_nios2_qsys_oci_dct_frame_reg.sv
// Valid/ready holding register for one packed frame (count + buffer).
// Ports: clk, reset_n, load/load_data in, out_ready in, out_valid/out_data/slot_free out.
module hello_nios2_qsys_oci_dct_frame_reg
  import hello_nios2_qsys_oci_dct_packer_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  frame_t load_data,
  input  logic   out_ready,
  output logic   out_valid,
  output frame_t out_data,
  output logic   slot_free
);

  logic   valid_q, valid_d;
  frame_t data_q, data_d;

  // Draining and refilling in one cycle is allowed.
  assign slot_free = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/hello_nios2_qsys_oci_dct_packer.sv
// OCI DCT packer: shifts 2-bit atoms into a 15-atom frame, emits full/flushed frames.
// Ports: clk, reset_n, bus (slave: atoms in, frames out, live buffer/count, sticky overflow).
module hello_nios2_qsys_oci_dct_packer
  import hello_nios2_qsys_oci_dct_packer_pkg::*;
(
  input logic clk,
  input logic reset_n,
  hello_nios2_qsys_oci_dct_packer_if.slave bus
);

  state_e           state_q, state_d;
  logic [BUF_W-1:0] sh_q, sh_d, sh_acc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_acc;
  logic             pend_q, pend_d;
  logic             ov_q, ov_d;

  logic   ready, accept, drop;
  logic   slot_free, flush_req, xfer;
  logic   fr_valid;
  frame_t fr_in, fr_out;

  assign ready  = !((state_q == ST_FULL) || pend_q);
  assign accept = bus.atom_valid && ready;
  assign drop   = bus.atom_valid && !ready;

  // Accumulator as it would look with this cycle's atom included.
  always_comb begin
    sh_acc  = sh_q;
    cnt_acc = cnt_q;
    if (accept) begin
      sh_acc  = {sh_q[BUF_W-ATOM_W-1:0], bus.atom_data};
      cnt_acc = cnt_q + CNT_W'(1);
    end
  end

  assign flush_req = (bus.flush || pend_q) && (cnt_acc != '0);
  assign xfer = slot_free &&
                (flush_req || (cnt_acc == FULL_CNT));

  assign fr_in = '{count: cnt_acc, buffer: sh_acc};

  always_comb begin
    sh_d   = sh_acc;
    cnt_d  = cnt_acc;
    pend_d = pend_q;
    if (xfer) begin
      sh_d   = '0;
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (flush_req) begin
      pend_d = 1'b1;
    end
  end

  // A count of 15 survives the edge only when the slot was busy.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (cnt_d == '0):       state_d = ST_EMPTY;
      (cnt_d == FULL_CNT): state_d = ST_FULL;
      default:             state_d = ST_FILL;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ov_d = ov_q;
    if (drop) begin
      ov_d = 1'b1;
    end else if (bus.clear_overflow) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      sh_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
    end
  end

  hello_nios2_qsys_oci_dct_frame_reg u_frame (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (xfer),
    .load_data (fr_in),
    .out_ready (bus.frame_ready),
    .out_valid (fr_valid),
    .out_data  (fr_out),
    .slot_free (slot_free)
  );

  assign bus.atom_ready   = ready;
  assign bus.frame_valid  = fr_valid;
  assign bus.frame_buffer = fr_out.buffer;
  assign bus.frame_count  = fr_out.count;
  assign bus.dct_buffer   = sh_q;
  assign bus.dct_count    = cnt_q;
  assign bus.overflow     = ov_q;

endmodule

// File: tb/tb_hello_nios2_qsys_oci_dct_packer.sv
// Bench for the DCT packer: queue-based reference model feeding a frame scoreboard.
// Directed scenarios followed by randomized traffic.
module tb_hello_nios2_qsys_oci_dct_packer;
  import hello_nios2_qsys_oci_dct_packer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  hello_nios2_qsys_oci_dct_packer_if bus();

  hello_nios2_qsys_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          cnt;
    logic [31:0] bits;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_acc[$];
  bit         m_busy, m_pend, m_ov;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Oldest atom ends up in the highest occupied bits.
  function automatic logic [31:0] pack(input logic [1:0] q[$]);
    logic [31:0] r;
    r = 0;
    foreach (q[i]) r = (r << 2) | 32'(q[i]);
    return r & 32'h3FFF_FFFF;
  endfunction

  task automatic model_step(input bit v, input logic [1:0] d,
                            input bit fl, input bit fr, input bit clr);
    bit rdy, free, want;
    rdy  = !(m_acc.size() == 15 || m_pend);
    free = !m_busy || fr;
    if (v && rdy) m_acc.push_back(d);
    if (v && !rdy) m_ov = 1;
    else if (clr) m_ov = 0;
    want = (m_acc.size() == 15) ||
           ((fl || m_pend) && m_acc.size() > 0);
    if (want && free) begin
      sb.push_back('{cnt: m_acc.size(), bits: pack(m_acc)});
      m_acc.delete();
      m_pend = 0;
      m_busy = 1;
    end else begin
      if ((fl || m_pend) && m_acc.size() > 0) m_pend = 1;
      if (fr) m_busy = 0;
    end
  endtask

  task automatic check_state();
    chk("atom_ready", 32'(bus.atom_ready),
        32'(!(m_acc.size() == 15 || m_pend)));
    chk("dct_count", 32'(bus.dct_count), m_acc.size());
    chk("dct_buffer", 32'(bus.dct_buffer), pack(m_acc));
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_busy));
    chk("overflow", 32'(bus.overflow), 32'(m_ov));
  endtask

  task automatic step(input bit v, input logic [1:0] d,
                      input bit fl, input bit fr, input bit clr);
    check_state();
    bus.atom_valid     = v;
    bus.atom_data      = d;
    bus.flush          = fl;
    bus.frame_ready    = fr;
    bus.clear_overflow = clr;
    model_step(v, d, fl, fr, clr);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    bus.atom_valid     = 0;
    bus.atom_data      = 0;
    bus.flush          = 0;
    bus.frame_ready    = 0;
    bus.clear_overflow = 0;
    reset_n = 0;
    #1;
    chk("rst_frame_valid", 32'(bus.frame_valid), 0);
    chk("rst_frame_buffer", 32'(bus.frame_buffer), 0);
    chk("rst_frame_count", 32'(bus.frame_count), 0);
    chk("rst_dct_buffer", 32'(bus.dct_buffer), 0);
    chk("rst_dct_count", 32'(bus.dct_count), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_atom_ready", 32'(bus.atom_ready), 1);
    m_acc.delete();
    sb.delete();
    m_busy = 0;
    m_pend = 0;
    m_ov   = 0;
    @(posedge clk);
    #2;
    reset_n = 1;
  endtask

  // Frame monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.frame_valid && bus.frame_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_frame", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("frame_count", 32'(bus.frame_count), 32'(e.cnt));
        chk("frame_buffer", 32'(bus.frame_buffer), e.bits);
      end
    end
  end

  initial begin
    bus.atom_valid     = 0;
    bus.atom_data      = 0;
    bus.flush          = 0;
    bus.frame_ready    = 0;
    bus.clear_overflow = 0;
    #3;
    @(posedge clk);
    #2;
    do_reset();

    // Fifteen 01 atoms back to back.
    for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 1, 0);
    chk("t1_valid", 32'(bus.frame_valid), 1);
    chk("t1_buffer", 32'(bus.frame_buffer), 32'h1555_5555);
    chk("t1_count", 32'(bus.frame_count), 15);
    chk("t1_dct_count", 32'(bus.dct_count), 0);
    step(0, 0, 0, 1, 0);

    // Three atoms then flush.
    step(1, 2'b11, 0, 1, 0);
    step(1, 2'b00, 0, 1, 0);
    step(1, 2'b10, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("t2_count", 32'(bus.frame_count), 3);
    chk("t2_buffer", 32'(bus.frame_buffer), 32'h32);
    step(0, 0, 0, 1, 0);

    // Writer stalled: second frame parks in the accumulator.
    for (int i = 0; i < 30; i++) step(1, 2'($urandom), 0, 0, 0);
    chk("t3_ready_low", 32'(bus.atom_ready), 0);
    step(1, 2'($urandom), 0, 0, 0);
    chk("t3_overflow", 32'(bus.overflow), 1);
    step(0, 0, 0, 1, 0);
    chk("t3_second_valid", 32'(bus.frame_valid), 1);
    chk("t3_second_count", 32'(bus.frame_count), 15);
    step(0, 0, 0, 1, 1);

    // Flush coinciding with the 5th atom, then an empty flush.
    for (int i = 0; i < 4; i++) step(1, 2'($urandom), 0, 1, 0);
    step(1, 2'($urandom), 1, 1, 0);
    chk("t4_count", 32'(bus.frame_count), 5);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("t4_empty_flush", 32'(bus.frame_valid), 0);

    // Reset mid-fill while a frame is held.
    for (int i = 0; i < 22; i++) step(1, 2'($urandom), 0, 0, 0);
    chk("t5_count7", 32'(bus.dct_count), 7);
    chk("t5_held", 32'(bus.frame_valid), 1);
    do_reset();

    // Pending flush blocks atoms; overflow set/clear priority.
    step(1, 2'($urandom), 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 2'($urandom), 1, 0, 0);
    chk("t6_pend_ready", 32'(bus.atom_ready), 0);
    step(1, 2'($urandom), 0, 0, 0);
    chk("t6_ov_set", 32'(bus.overflow), 1);
    step(0, 0, 0, 0, 1);
    chk("t6_ov_clr", 32'(bus.overflow), 0);
    step(1, 2'($urandom), 0, 0, 0);
    step(1, 2'($urandom), 0, 0, 1);
    chk("t6_set_wins", 32'(bus.overflow), 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 2'($urandom),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
